prt_drain_ctrl: RTL and testbench

//  Sequencer between the firewall verdict stage and the PRT read/invalidate ports. Queues completed
//  PRT slots in finish order, each tagged forward or drop. Forwarded slots are streamed to the egress
//  MAC as a valid/ready word stream, then invalidated. Dropped slots are invalidated without a read.

---
 rtl/prt_pkg.sv | 22 ++
 rtl/prt_slot_fifo.sv | 94 +++++++++
 rtl/prt_drain_ctrl.sv | 166 ++++++++++++++++
 tb/tb_prt_drain_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prt_pkg.sv
// Shared types for the PRT drain sequencer: FSM state encoding and the queued slot request.
// The optional statistics block is enabled with the PRT_DRAIN_STATS_EN macro in prt_drain_ctrl.
package prt_pkg;

  // Slot field width of a queued request; covers PRT instances of up to 256 slots.
  localparam int PRT_MAX_SLOT_W = 8;

  typedef logic [PRT_MAX_SLOT_W-1:0] prt_slot_t;

  typedef enum logic [1:0] {
    IDLE,
    START_RD,
    READ,
    INVAL
  } prt_drain_state_e;

  typedef struct packed {
    prt_slot_t slot;
    logic      drop;
  } prt_slot_req_t;

endpackage

// File: rtl/prt_slot_fifo.sv
// Ring FIFO of completed-slot requests with registered-count full/empty.
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
module prt_slot_fifo
  import prt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  prt_slot_req_t wdata,
  input  logic          pop,
  output prt_slot_req_t rdata,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  prt_slot_req_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             push_ok;
  logic             pop_ok;
  logic             dup_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (push_ok) begin
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      vld_d[wr_ptr_q] = 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d        = ptr_inc(rd_ptr_q);
      vld_d[rd_ptr_q] = 1'b0;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // A slot id may be queued at most once; the valid mask exists only to check that.
  always_comb begin
    dup_push = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld_q[k] && (mem_q[k].slot == wdata.slot)) begin
        dup_push = 1'b1;
      end
    end
  end

  a_no_dup_slot : assert property (@(posedge clk) disable iff (!rst_n) !(push && dup_push))
    else $error("prt_slot_fifo: slot id pushed while already queued");

endmodule

// File: rtl/prt_drain_ctrl.sv
// Drains completed PRT slots in finish order: forwards stream the entry to egress then invalidate,
// drops invalidate directly. Optional saturating counters under `ifdef PRT_DRAIN_STATS_EN.
module prt_drain_ctrl
  import prt_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_SLOTS  = 2,
  parameter  int STAT_W     = 32,
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  input  logic [SLOT_W-1:0]     in_slot,
  input  logic                  in_drop,
  output logic                  in_ready,
  output logic                  prt_en_start_reading,
  output logic [SLOT_W-1:0]     prt_start_reading_slot,
  input  logic                  prt_rdy_start_reading,
  output logic                  prt_en_read,
  input  logic [DATA_WIDTH:0]   prt_read_entry,
  input  logic                  prt_rdy_read,
  output logic                  prt_en_invalidate,
  output logic [SLOT_W-1:0]     prt_invalidate_slot,
  input  logic                  prt_rdy_invalidate,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [STAT_W-1:0]     stat_fwd,
  output logic [STAT_W-1:0]     stat_drop,
  output logic [STAT_W-1:0]     stat_words
);

  // Handshakes: a transfer happens in a cycle where valid (or a PRT EN) and its ready (or RDY)
  // are both high; a valid is never withdrawn and its payload never changes until it transfers.

  prt_drain_state_e    state_q, state_d;
  logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
  logic                cur_drop_q, cur_drop_d;
  prt_slot_req_t       push_req;
  prt_slot_req_t       head_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  assign push_req.slot = PRT_MAX_SLOT_W'(in_slot);
  assign push_req.drop = in_drop;
  assign in_ready      = !fifo_full;

  prt_slot_fifo #(
    .DEPTH(NUM_SLOTS)
  ) u_slot_fifo (
    .clk  (CLK),
    .rst_n(RST_N),
    .push (in_valid && in_ready),
    .wdata(push_req),
    .pop  (fifo_pop),
    .rdata(head_req),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d              = state_q;
    cur_slot_d           = cur_slot_q;
    cur_drop_d           = cur_drop_q;
    fifo_pop             = 1'b0;
    prt_en_start_reading = 1'b0;
    prt_en_read          = 1'b0;
    prt_en_invalidate    = 1'b0;
    out_valid            = 1'b0;
    out_data             = '0;
    out_last             = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_slot_d = SLOT_W'(head_req.slot);
          cur_drop_d = head_req.drop;
          state_d    = head_req.drop ? INVAL : START_RD;
        end
      end
      START_RD: begin
        prt_en_start_reading = prt_rdy_start_reading;
        if (prt_rdy_start_reading) state_d = READ;
      end
      READ: begin
        // The PRT holds the current word until EN_read, so a stalled egress sees stable data.
        out_valid   = prt_rdy_read;
        out_data    = prt_read_entry[DATA_WIDTH-1:0];
        out_last    = prt_read_entry[DATA_WIDTH];
        prt_en_read = prt_rdy_read && out_ready;
        if (prt_en_read && prt_read_entry[DATA_WIDTH]) state_d = INVAL;
      end
      INVAL: begin
        prt_en_invalidate = prt_rdy_invalidate;
        if (prt_rdy_invalidate) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cur_slot_q <= '0;
      cur_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_slot_q <= cur_slot_d;
      cur_drop_q <= cur_drop_d;
    end
  end

  assign prt_start_reading_slot = cur_slot_q;
  assign prt_invalidate_slot    = cur_slot_q;
  assign busy                   = (state_q != IDLE) || !fifo_empty;

  a_en_onehot : assert property (@(posedge CLK) disable iff (!RST_N)
    $onehot0({prt_en_start_reading, prt_en_read, prt_en_invalidate}))
    else $error("prt_drain_ctrl: more than one PRT method enabled");

`ifdef PRT_DRAIN_STATS_EN
  logic [STAT_W-1:0] stat_fwd_q, stat_fwd_d;
  logic [STAT_W-1:0] stat_drop_q, stat_drop_d;
  logic [STAT_W-1:0] stat_words_q, stat_words_d;

  always_comb begin
    stat_fwd_d   = stat_fwd_q;
    stat_drop_d  = stat_drop_q;
    stat_words_d = stat_words_q;
    if (prt_en_invalidate && !cur_drop_q && (stat_fwd_q != '1)) begin
      stat_fwd_d = stat_fwd_q + STAT_W'(1);
    end
    if (prt_en_invalidate && cur_drop_q && (stat_drop_q != '1)) begin
      stat_drop_d = stat_drop_q + STAT_W'(1);
    end
    if (prt_en_read && (stat_words_q != '1)) begin
      stat_words_d = stat_words_q + STAT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_fwd_q   <= '0;
      stat_drop_q  <= '0;
      stat_words_q <= '0;
    end else begin
      stat_fwd_q   <= stat_fwd_d;
      stat_drop_q  <= stat_drop_d;
      stat_words_q <= stat_words_d;
    end
  end

  assign stat_fwd   = stat_fwd_q;
  assign stat_drop  = stat_drop_q;
  assign stat_words = stat_words_q;
`else
  assign stat_fwd   = '0;
  assign stat_drop  = '0;
  assign stat_words = '0;
`endif

endmodule

// File: tb/tb_prt_drain_ctrl.sv
// Directed bench for prt_drain_ctrl with a behavioural PRT read model and an event scoreboard.
module tb_prt_drain_ctrl;

`ifdef PRT_DRAIN_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic        CLK;
  logic        RST_N;
  logic        in_valid;
  logic [0:0]  in_slot;
  logic        in_drop;
  logic        in_ready;
  logic        prt_en_start_reading;
  logic [0:0]  prt_start_reading_slot;
  logic        prt_rdy_start_reading;
  logic        prt_en_read;
  logic [8:0]  prt_read_entry;
  logic        prt_rdy_read;
  logic        prt_en_invalidate;
  logic [0:0]  prt_invalidate_slot;
  logic        prt_rdy_invalidate;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic [31:0] stat_fwd;
  logic [31:0] stat_drop;
  logic [31:0] stat_words;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  // PRT model storage and read state
  logic [7:0]  mem [2][8];
  int          len [2];
  logic        rd_act;
  logic        rd_slot;
  int          rd_idx;

  prt_drain_ctrl #(
    .DATA_WIDTH(8),
    .NUM_SLOTS (2),
    .STAT_W    (32)
  ) dut (
    .CLK                   (CLK),
    .RST_N                 (RST_N),
    .in_valid              (in_valid),
    .in_slot               (in_slot),
    .in_drop               (in_drop),
    .in_ready              (in_ready),
    .prt_en_start_reading  (prt_en_start_reading),
    .prt_start_reading_slot(prt_start_reading_slot),
    .prt_rdy_start_reading (prt_rdy_start_reading),
    .prt_en_read           (prt_en_read),
    .prt_read_entry        (prt_read_entry),
    .prt_rdy_read          (prt_rdy_read),
    .prt_en_invalidate     (prt_en_invalidate),
    .prt_invalidate_slot   (prt_invalidate_slot),
    .prt_rdy_invalidate    (prt_rdy_invalidate),
    .out_valid             (out_valid),
    .out_data              (out_data),
    .out_last              (out_last),
    .out_ready             (out_ready),
    .busy                  (busy),
    .stat_fwd              (stat_fwd),
    .stat_drop             (stat_drop),
    .stat_words            (stat_words)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- PRT model ----------------
  assign prt_rdy_read = rd_act;

  always_comb begin
    prt_read_entry = '0;
    if (rd_act) begin
      if (len[rd_slot] == 0) prt_read_entry = 9'h100;
      else prt_read_entry = {(rd_idx == len[rd_slot] - 1), mem[rd_slot][rd_idx]};
    end
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_act  <= 1'b0;
      rd_slot <= 1'b0;
      rd_idx  <= 0;
    end else if (prt_en_start_reading) begin
      rd_act  <= 1'b1;
      rd_slot <= prt_start_reading_slot;
      rd_idx  <= 0;
    end else if (prt_en_read) begin
      if (prt_read_entry[8]) rd_act <= 1'b0;
      else rd_idx <= rd_idx + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ev(input int t, input int v);
    return (t << 16) | v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int slot, input int n, input int base);
    len[slot] = n;
    for (int i = 0; i < 8; i++) mem[slot][i] = 8'(base + i);
  endtask

  task automatic exp_fwd(input int slot, input int n, input int base);
    exp_q.push_back(mk_ev(1, slot));
    if (n == 0) exp_q.push_back(mk_ev(2, 32'h100));
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk_ev(2, ((i == n - 1) ? 32'h100 : 32'h0) | ((base + i) & 32'hff)));
    exp_q.push_back(mk_ev(3, slot));
  endtask

  task automatic check_stats(input string tag, input int f, input int d, input int w);
    check({tag, "_stat_fwd"},   stat_fwd,   32'(STATS_ON * f));
    check({tag, "_stat_drop"},  stat_drop,  32'(STATS_ON * d));
    check({tag, "_stat_words"}, stat_words, 32'(STATS_ON * w));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    logic [31:0] ev;
    bit          have;
    if (RST_N) begin
      have = 1'b0;
      ev   = '0;
      if (prt_en_start_reading) begin
        ev = mk_ev(1, int'(prt_start_reading_slot)); have = 1'b1;
      end else if (out_valid && out_ready) begin
        ev = mk_ev(2, int'({out_last, out_data})); have = 1'b1;
      end else if (prt_en_invalidate) begin
        ev = mk_ev(3, int'(prt_invalidate_slot)); have = 1'b1;
      end
      check("mon_en_read_hs", 32'(prt_en_read), 32'(out_valid && out_ready));
      check("mon_en_onehot", 32'($onehot0({prt_en_start_reading, prt_en_read, prt_en_invalidate})), 32'd1);
      if (have) begin
        if (exp_q.size() == 0) check("mon_unexpected_event", ev, 32'hffffffff);
        else check("mon_event_order", ev, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit pat [7];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    RST_N                 = 1'b0;
    in_valid              = 1'b0;
    in_slot               = 1'b0;
    in_drop               = 1'b0;
    out_ready             = 1'b1;
    prt_rdy_start_reading = 1'b1;
    prt_rdy_invalidate    = 1'b1;
    load(0, 0, 0);
    load(1, 0, 0);
    repeat (2) @(posedge CLK);
    #1;

    // reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_en_start", prt_en_start_reading, 0);
    check("rst_en_read", prt_en_read, 0);
    check("rst_en_inval", prt_en_invalidate, 0);
    check_stats("rst", 0, 0, 0);
    RST_N = 1'b1;
    tick();

    // 1: forward slot0, 5 words, with RDY gating on start and invalidate
    load(0, 5, 0);
    exp_fwd(0, 5, 0);
    prt_rdy_start_reading = 1'b0;
    in_valid = 1'b1; in_slot = 1'b0; in_drop = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    check("t1_busy", busy, 1);
    check("t1_idle_en_start", prt_en_start_reading, 0);
    tick();
    check("t1_start_gated", prt_en_start_reading, 0);
    prt_rdy_start_reading = 1'b1;
    #1;
    check("t1_en_start", prt_en_start_reading, 1);
    check("t1_start_slot", prt_start_reading_slot, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t1_out_valid", out_valid, 1);
      check("t1_out_data", out_data, 32'(i));
      check("t1_out_last", out_last, 32'(i == 4));
      check("t1_en_read", prt_en_read, 1);
      if (i == 4) prt_rdy_invalidate = 1'b0;
      tick();
    end
    check("t1_inval_gated", prt_en_invalidate, 0);
    check("t1_no_out_in_inval", out_valid, 0);
    tick();
    prt_rdy_invalidate = 1'b1;
    #1;
    check("t1_en_inval", prt_en_invalidate, 1);
    check("t1_inval_slot", prt_invalidate_slot, 0);
    tick();
    check("t1_busy_done", busy, 0);

    // 2: drop slot1
    exp_q.push_back(mk_ev(3, 1));
    in_valid = 1'b1; in_slot = 1'b1; in_drop = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("t2_pop_en_start", prt_en_start_reading, 0);
    check("t2_pop_en_inval", prt_en_invalidate, 0);
    check("t2_pop_busy", busy, 1);
    tick();
    check("t2_en_inval", prt_en_invalidate, 1);
    check("t2_inval_slot", prt_invalidate_slot, 1);
    check("t2_en_start", prt_en_start_reading, 0);
    check("t2_out_valid", out_valid, 0);
    tick();
    check("t2_busy_done", busy, 0);
    check_stats("t2", 1, 1, 5);

    // 3: two forwards back-to-back, ordering via scoreboard
    load(0, 3, 8'h10);
    load(1, 3, 8'h20);
    exp_fwd(0, 3, 8'h10);
    exp_fwd(1, 3, 8'h20);
    in_valid = 1'b1; in_slot = 1'b0; in_drop = 1'b0;
    tick();
    check("t3_ready_after_1st", in_ready, 1);
    in_slot = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("t3_ready_after_2nd", in_ready, 1);
    check("t3_busy", busy, 1);
    repeat (5) tick();
    check("t3_mid_idle_busy", busy, 1);
    check("t3_mid_idle_en_start", prt_en_start_reading, 0);
    check("t3_mid_idle_out_valid", out_valid, 0);
    repeat (6) tick();
    check("t3_busy_done", busy, 0);

    // 4: egress stalls during a 4-word packet, queue filled to capacity meanwhile
    load(1, 4, 8'h30);
    exp_fwd(1, 4, 8'h30);
    exp_q.push_back(mk_ev(3, 0));
    exp_q.push_back(mk_ev(3, 1));
    in_valid = 1'b1; in_slot = 1'b1; in_drop = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    k = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = pat[c];
      in_valid  = (c == 1) || (c == 2);
      in_slot   = (c == 1) ? 1'b0 : 1'b1;
      in_drop   = 1'b1;
      #1;
      check("t4_out_valid", out_valid, 1);
      check("t4_out_data", out_data, 32'(8'h30 + k));
      check("t4_out_last", out_last, 32'(k == 3));
      check("t4_en_read", prt_en_read, 32'(pat[c]));
      if (c >= 3) check("t4_full_in_ready", in_ready, 0);
      if (pat[c]) k++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t4_en_inval_fwd", prt_en_invalidate, 1);
    check("t4_inval_slot_fwd", prt_invalidate_slot, 1);
    check("t4_full_at_inval", in_ready, 0);
    tick();
    check("t4_full_during_pop", in_ready, 0);
    check("t4_pop_busy", busy, 1);
    tick();
    check("t4_ready_after_pop", in_ready, 1);
    check("t4_en_inval_d0", prt_en_invalidate, 1);
    check("t4_inval_slot_d0", prt_invalidate_slot, 0);
    tick();
    tick();
    check("t4_en_inval_d1", prt_en_invalidate, 1);
    check("t4_inval_slot_d1", prt_invalidate_slot, 1);
    tick();
    check("t4_busy_done", busy, 0);

    // 5: zero-length forward
    load(0, 0, 0);
    exp_fwd(0, 0, 0);
    in_valid = 1'b1; in_slot = 1'b0; in_drop = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_en_start", prt_en_start_reading, 1);
    tick();
    check("t5_out_valid", out_valid, 1);
    check("t5_out_last", out_last, 1);
    check("t5_out_data", out_data, 0);
    check("t5_en_read", prt_en_read, 1);
    tick();
    check("t5_en_inval", prt_en_invalidate, 1);
    check("t5_inval_slot", prt_invalidate_slot, 0);
    tick();
    check("t5_busy_done", busy, 0);
    check_stats("t5", 5, 3, 16);

    // 6: asynchronous reset in the middle of a packet, with a drop still queued
    load(0, 5, 8'h40);
    exp_q.push_back(mk_ev(1, 0));
    exp_q.push_back(mk_ev(2, 8'h40));
    exp_q.push_back(mk_ev(2, 8'h41));
    in_valid = 1'b1; in_slot = 1'b0; in_drop = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_slot = 1'b1; in_drop = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_word2_data", out_data, 8'h42);
    check("t6_word2_valid", out_valid, 1);
    RST_N = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_out_last", out_last, 0);
    check("t6_rst_en_read", prt_en_read, 0);
    check("t6_rst_en_inval", prt_en_invalidate, 0);
    check("t6_rst_en_start", prt_en_start_reading, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_in_ready", in_ready, 1);
    check_stats("t6_rst", 0, 0, 0);
    check("t6_events_seen", 32'(exp_q.size()), 0);
    exp_q.delete();
    tick();
    RST_N = 1'b1;
    tick();
    check("t6_post_rst_busy", busy, 0);
    load(1, 2, 8'h50);
    exp_fwd(1, 2, 8'h50);
    in_valid = 1'b1; in_slot = 1'b1; in_drop = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("t6_busy_done", busy, 0);
    check_stats("t6", 1, 0, 2);

    tick();
    check("end_exp_q_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
